// File: rtl/alu_selftest_engine.sv
// -----------------------------------------------------------------------------
// alu_selftest_engine
//
// Purpose:
//   Built-in self-test sequencer for the ALU. Packed stimulus/expected-response
//   packets are read one at a time from a synchronous ROM. Each packet's ALU
//   inputs are driven onto the DUT_* outputs. After LATENCY cycles the ALU
//   result and flags are compared against the packet's expected vector.
//   Pass/fail counts are kept, and the Feature_ID of the first failing packet
//   is captured. A run can optionally stop at the first failure.
//
// Packet layout (MSB -> LSB):
//   FEATURE_ID[8], CE, MODE, CMD[4], INP_VALID[2], OPA[W], OPB[W], CIN,
//   EXP_RES[2W], COUT, OFLOW, ERR, G, L, E, NEG, ZERO
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   START                one-cycle pulse that starts a run (ignored while BUSY)
//   STOP_ON_FAIL         sampled at START; end the run at the first failure
//   STIM_RD, STIM_ADDR   ROM read strobe and address
//   STIM_DATA            ROM packet, valid the cycle after STIM_RD
//   DUT_CE .. DUT_OPB    registered ALU input drive
//   DUT_RES .. DUT_ZERO  ALU result and flags to be checked
//   BUSY, DONE           run in progress / run finished (DONE held until START/RST)
//   PASS_CNT, FAIL_CNT   per-run test counts
//   FIRST_FAIL_VALID/ID  first failing packet's Feature_ID capture
// -----------------------------------------------------------------------------
module alu_selftest_engine #(
    parameter int WIDTH     = 8,
    parameter int NUM_TESTS = 56,
    parameter int ADDR_W    = 6,
    parameter int LATENCY   = 2,
    localparam int PKT_W    = 4*WIDTH+25
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  STOP_ON_FAIL,
    output logic                  STIM_RD,
    output logic [ADDR_W-1:0]     STIM_ADDR,
    input  logic [PKT_W-1:0]      STIM_DATA,
    output logic                  DUT_CE,
    output logic                  DUT_MODE,
    output logic                  DUT_CIN,
    output logic [3:0]            DUT_CMD,
    output logic [1:0]            DUT_INP_VALID,
    output logic [WIDTH-1:0]      DUT_OPA,
    output logic [WIDTH-1:0]      DUT_OPB,
    input  logic [2*WIDTH-1:0]    DUT_RES,
    input  logic                  DUT_COUT,
    input  logic                  DUT_OFLOW,
    input  logic                  DUT_ERR,
    input  logic                  DUT_G,
    input  logic                  DUT_L,
    input  logic                  DUT_E,
    input  logic                  DUT_NEG,
    input  logic                  DUT_ZERO,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [ADDR_W:0]       PASS_CNT,
    output logic [ADDR_W:0]       FAIL_CNT,
    output logic                  FIRST_FAIL_VALID,
    output logic [7:0]            FIRST_FAIL_ID
);

    localparam int CMP_W    = 2*WIDTH+8;
    localparam int CNT_W    = ADDR_W+1;
    localparam int WCNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Bit offsets of the packet fields, counted from the LSB
    localparam int F_CIN    = 2*WIDTH+8;
    localparam int F_OPB_LO = 2*WIDTH+9;
    localparam int F_OPA_LO = 3*WIDTH+9;
    localparam int F_IV_LO  = 4*WIDTH+9;
    localparam int F_CMD_LO = 4*WIDTH+11;
    localparam int F_MODE   = 4*WIDTH+15;
    localparam int F_CE     = 4*WIDTH+16;
    localparam int F_FID_LO = 4*WIDTH+17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_CHECK,
        S_FIN
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [ADDR_W-1:0]   test_idx;
    logic [WCNT_W-1:0]   wait_cnt;
    logic                stop_q;
    logic [CMP_W-1:0]    exp_q;
    logic [7:0]          feature_q;

    logic [CMP_W-1:0]    observed;
    logic                mismatch;
    logic                last_test;
    logic                end_run;
    logic                start_run;

    assign observed  = {DUT_RES, DUT_COUT, DUT_OFLOW, DUT_ERR,
                        DUT_G, DUT_L, DUT_E, DUT_NEG, DUT_ZERO};
    assign mismatch  = (observed != exp_q);
    assign last_test = (test_idx == ADDR_W'(NUM_TESTS-1));
    assign end_run   = last_test || (mismatch && stop_q);
    assign STIM_ADDR = test_idx;

    // State register; reset abandons any run in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status decode. A run may be (re)started from IDLE or FIN
    // only, which is what makes START ignored while BUSY.
    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        STIM_RD    = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    start_run  = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                BUSY       = 1'b1;
                STIM_RD    = 1'b1;
                next_state = S_LOAD;
            end
            S_LOAD: begin
                BUSY       = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                BUSY = 1'b1;
                if (wait_cnt == '0) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                BUSY       = 1'b1;
                next_state = end_run ? S_FIN : S_FETCH;
            end
            S_FIN: begin
                DONE = 1'b1;
                if (START) begin
                    start_run  = 1'b1;
                    next_state = S_FETCH;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: run setup, packet load onto the ALU drive registers, latency
    // countdown and result scoring. The ALU drive registers only change in LOAD,
    // so they keep the last packet after the run ends.
    always_ff @(posedge CLK) begin
        if (RST) begin
            test_idx         <= '0;
            wait_cnt         <= '0;
            stop_q           <= 1'b0;
            exp_q            <= '0;
            feature_q        <= '0;
            PASS_CNT         <= '0;
            FAIL_CNT         <= '0;
            FIRST_FAIL_VALID <= 1'b0;
            FIRST_FAIL_ID    <= '0;
            DUT_CE           <= 1'b0;
            DUT_MODE         <= 1'b0;
            DUT_CIN          <= 1'b0;
            DUT_CMD          <= '0;
            DUT_INP_VALID    <= '0;
            DUT_OPA          <= '0;
            DUT_OPB          <= '0;
        end else begin
            if (start_run) begin
                test_idx         <= '0;
                PASS_CNT         <= '0;
                FAIL_CNT         <= '0;
                FIRST_FAIL_VALID <= 1'b0;
                FIRST_FAIL_ID    <= '0;
                stop_q           <= STOP_ON_FAIL;
            end

            if (state == S_LOAD) begin
                DUT_CE        <= STIM_DATA[F_CE];
                DUT_MODE      <= STIM_DATA[F_MODE];
                DUT_CMD       <= STIM_DATA[F_CMD_LO +: 4];
                DUT_INP_VALID <= STIM_DATA[F_IV_LO +: 2];
                DUT_OPA       <= STIM_DATA[F_OPA_LO +: WIDTH];
                DUT_OPB       <= STIM_DATA[F_OPB_LO +: WIDTH];
                DUT_CIN       <= STIM_DATA[F_CIN];
                exp_q         <= STIM_DATA[CMP_W-1:0];
                feature_q     <= STIM_DATA[F_FID_LO +: 8];
                wait_cnt      <= WCNT_W'(LATENCY-1);
            end

            if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WCNT_W'(1);
            end

            if (state == S_CHECK) begin
                if (mismatch) begin
                    FAIL_CNT <= FAIL_CNT + CNT_W'(1);
                    if (!FIRST_FAIL_VALID) begin
                        FIRST_FAIL_VALID <= 1'b1;
                        FIRST_FAIL_ID    <= feature_q;
                    end
                end else begin
                    PASS_CNT <= PASS_CNT + CNT_W'(1);
                end
                if (!end_run) begin
                    test_idx <= test_idx + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_selftest_engine.sv
// -----------------------------------------------------------------------------
// tb_alu_selftest_engine
//
// Drives two engine instances: an 8-bit one with four packets and a 16-bit one
// with a single multiply packet. Each instance has a small stimulus ROM and a
// behavioural stand-in for the ALU. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_alu_selftest_engine;

    logic        CLK;
    logic        RST;
    int          compare_count;
    int          fail_count;

    // ---------------- 8-bit instance signals ----------------
    logic        start8;
    logic        stop8;
    logic        stim_rd8;
    logic [5:0]  stim_addr8;
    logic [56:0] stim_data8;
    logic        ce8, mode8, cin8;
    logic [3:0]  cmd8;
    logic [1:0]  iv8;
    logic [7:0]  opa8, opb8;
    logic [15:0] res8;
    logic        cout8, oflow8, err8, g8, l8, e8, neg8, zero8;
    logic        busy8, done8;
    logic [6:0]  pass8, fail8;
    logic        ffv8;
    logic [7:0]  ffid8;
    logic [56:0] rom8 [0:3];
    logic [5:0]  max_addr8;
    logic        clr_max;

    // ---------------- 16-bit instance signals ----------------
    logic        start16;
    logic        stim_rd16;
    logic [0:0]  stim_addr16;
    logic [88:0] stim_data16;
    logic        ce16, mode16, cin16;
    logic [3:0]  cmd16;
    logic [1:0]  iv16;
    logic [15:0] opa16, opb16;
    logic [31:0] res16;
    logic        zero16;
    logic        busy16, done16;
    logic [1:0]  pass16, fail16;
    logic        ffv16;
    logic [7:0]  ffid16;
    logic [88:0] rom16;

    alu_selftest_engine #(
        .WIDTH(8), .NUM_TESTS(4), .ADDR_W(6), .LATENCY(2)
    ) dut8 (
        .CLK(CLK), .RST(RST), .START(start8), .STOP_ON_FAIL(stop8),
        .STIM_RD(stim_rd8), .STIM_ADDR(stim_addr8), .STIM_DATA(stim_data8),
        .DUT_CE(ce8), .DUT_MODE(mode8), .DUT_CIN(cin8), .DUT_CMD(cmd8),
        .DUT_INP_VALID(iv8), .DUT_OPA(opa8), .DUT_OPB(opb8),
        .DUT_RES(res8), .DUT_COUT(cout8), .DUT_OFLOW(oflow8), .DUT_ERR(err8),
        .DUT_G(g8), .DUT_L(l8), .DUT_E(e8), .DUT_NEG(neg8), .DUT_ZERO(zero8),
        .BUSY(busy8), .DONE(done8), .PASS_CNT(pass8), .FAIL_CNT(fail8),
        .FIRST_FAIL_VALID(ffv8), .FIRST_FAIL_ID(ffid8)
    );

    alu_selftest_engine #(
        .WIDTH(16), .NUM_TESTS(1), .ADDR_W(1), .LATENCY(2)
    ) dut16 (
        .CLK(CLK), .RST(RST), .START(start16), .STOP_ON_FAIL(1'b0),
        .STIM_RD(stim_rd16), .STIM_ADDR(stim_addr16), .STIM_DATA(stim_data16),
        .DUT_CE(ce16), .DUT_MODE(mode16), .DUT_CIN(cin16), .DUT_CMD(cmd16),
        .DUT_INP_VALID(iv16), .DUT_OPA(opa16), .DUT_OPB(opb16),
        .DUT_RES(res16), .DUT_COUT(1'b0), .DUT_OFLOW(1'b0), .DUT_ERR(1'b0),
        .DUT_G(1'b0), .DUT_L(1'b0), .DUT_E(1'b0), .DUT_NEG(1'b0), .DUT_ZERO(zero16),
        .BUSY(busy16), .DONE(done16), .PASS_CNT(pass16), .FAIL_CNT(fail16),
        .FIRST_FAIL_VALID(ffv16), .FIRST_FAIL_ID(ffid16)
    );

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous stimulus ROMs: data is valid the cycle after the read strobe
    always @(posedge CLK) begin
        if (stim_rd8) begin
            stim_data8 <= (stim_addr8 < 6'd4) ? rom8[stim_addr8[1:0]] : 57'h0;
        end
        if (stim_rd16) begin
            stim_data16 <= rom16;
        end
    end

    // Highest ROM address the 8-bit engine has read since the last clear
    always @(posedge CLK) begin
        if (clr_max) begin
            max_addr8 <= 6'd0;
        end else if (stim_rd8 && (stim_addr8 > max_addr8)) begin
            max_addr8 <= stim_addr8;
        end
    end

    // Behavioural 8-bit ALU: ADD/SUB/CMP/MUL in arithmetic mode, AND in logic mode
    always_comb begin
        res8   = 16'h0;
        cout8  = 1'b0;
        oflow8 = 1'b0;
        err8   = 1'b0;
        g8     = 1'b0;
        l8     = 1'b0;
        e8     = 1'b0;
        neg8   = 1'b0;
        zero8  = 1'b0;
        if (ce8) begin
            if (iv8 != 2'b11) begin
                err8 = 1'b1;
            end else if (mode8) begin
                case (cmd8)
                    4'd0: begin
                        res8  = {8'h0, opa8} + {8'h0, opb8} + {15'h0, cin8};
                        cout8 = res8[8];
                    end
                    4'd1: begin
                        res8   = {8'h0, opa8 - opb8};
                        oflow8 = (opa8 < opb8);
                    end
                    4'd8: begin
                        g8 = (opa8 > opb8);
                        l8 = (opa8 < opb8);
                        e8 = (opa8 == opb8);
                    end
                    4'd9: res8 = {8'h0, opa8} * {8'h0, opb8};
                    default: res8 = 16'h0;
                endcase
            end else begin
                if (cmd8 == 4'd0) begin
                    res8 = {8'h0, opa8 & opb8};
                end
            end
            zero8 = (res8 == 16'h0);
        end
    end

    // Behavioural 16-bit ALU: only the multiply path matters here
    always_comb begin
        res16  = 32'h0;
        zero16 = 1'b0;
        if (ce16) begin
            if (mode16 && (cmd16 == 4'd9) && (iv16 == 2'b11)) begin
                res16 = {16'h0, opa16} * {16'h0, opb16};
            end
            zero16 = (res16 == 32'h0);
        end
    end

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [56:0] mkPkt8(input logic [7:0] fid, input logic ce,
                                           input logic mode, input logic [3:0] cmd,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input logic [15:0] res, input logic [7:0] flags);
        return {fid, ce, mode, cmd, 2'b11, a, b, 1'b0, res, flags};
    endfunction

    function automatic logic [88:0] mkPkt16(input logic [7:0] fid, input logic [15:0] a,
                                            input logic [15:0] b, input logic [31:0] res);
        return {fid, 1'b1, 1'b1, 4'd9, 2'b11, a, b, 1'b0, res, 8'h00};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Loads the consistent packet set into the 8-bit ROM
    task automatic loadGoodRom();
        rom8[0] = mkPkt8(8'h10, 1'b1, 1'b1, 4'd0, 8'hF0, 8'h20, 16'h0110, 8'b1000_0000);
        rom8[1] = mkPkt8(8'h11, 1'b1, 1'b1, 4'd1, 8'h05, 8'h07, 16'h00FE, 8'b0100_0000);
        rom8[2] = mkPkt8(8'h12, 1'b1, 1'b1, 4'd9, 8'h0C, 8'h0D, 16'h009C, 8'b0000_0000);
        rom8[3] = mkPkt8(8'h13, 1'b1, 1'b0, 4'd0, 8'hF0, 8'h0F, 16'h0000, 8'b0000_0001);
    endtask

    // Pulses START on the 8-bit engine; returns #1 after the START edge
    task automatic applyStimulus(input logic stop_on_fail);
        @(posedge CLK);
        #1;
        start8 = 1'b1;
        stop8  = stop_on_fail;
        @(posedge CLK);
        #1;
        start8 = 1'b0;
        stop8  = 1'b0;
    endtask

    // Counts edges (continuing from already_elapsed) until DONE, bounded
    task automatic waitDone8(input int already_elapsed, output int cycles);
        cycles = already_elapsed;
        while ((done8 !== 1'b1) && (cycles < 200)) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
    endtask

    task automatic clearMaxAddr();
        clr_max = 1'b1;
        @(posedge CLK);
        #1;
        clr_max = 1'b0;
    endtask

    initial begin
        int cyc;
        compare_count = 0;
        fail_count    = 0;
        RST           = 1'b1;
        start8        = 1'b0;
        stop8         = 1'b0;
        start16       = 1'b0;
        clr_max       = 1'b1;
        stim_data8    = '0;
        stim_data16   = '0;
        loadGoodRom();
        rom16 = mkPkt16(8'h60, 16'h0100, 16'h0100, 32'h0001_0000);

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_busy", busy8, 1'b0);
        checkOutput("rst_done", done8, 1'b0);
        checkOutput("rst_pass", pass8, 7'd0);
        checkOutput("rst_fail", fail8, 7'd0);
        checkOutput("rst_ffv", ffv8, 1'b0);
        checkOutput("rst_stim_rd", stim_rd8, 1'b0);
        checkOutput("rst_dut_ce", ce8, 1'b0);
        RST     = 1'b0;
        clr_max = 1'b0;

        // 1: all packets consistent
        $display("[TB] run 1: all packets consistent");
        applyStimulus(1'b0);
        checkOutput("t1_busy", busy8, 1'b1);
        checkOutput("t1_first_rd", stim_rd8, 1'b1);
        checkOutput("t1_first_addr", stim_addr8, 6'd0);
        waitDone8(0, cyc);
        checkOutput("t1_done_cycles", cyc, 20);
        checkOutput("t1_pass", pass8, 7'd4);
        checkOutput("t1_fail", fail8, 7'd0);
        checkOutput("t1_ffv", ffv8, 1'b0);
        checkOutput("t1_busy_fin", busy8, 1'b0);

        // 2: packet 2 expects the wrong result
        $display("[TB] run 2: packet 0x12 result off by one");
        rom8[2] = mkPkt8(8'h12, 1'b1, 1'b1, 4'd9, 8'h0C, 8'h0D, 16'h009D, 8'b0000_0000);
        applyStimulus(1'b0);
        waitDone8(0, cyc);
        checkOutput("t2_done_cycles", cyc, 20);
        checkOutput("t2_pass", pass8, 7'd3);
        checkOutput("t2_fail", fail8, 7'd1);
        checkOutput("t2_ffv", ffv8, 1'b1);
        checkOutput("t2_ffid", ffid8, 8'h12);

        // 3: packet 1 also expects COUT, stop on first fail
        $display("[TB] run 3: stop on first fail");
        rom8[1] = mkPkt8(8'h11, 1'b1, 1'b1, 4'd1, 8'h05, 8'h07, 16'h00FE, 8'b1100_0000);
        clearMaxAddr();
        applyStimulus(1'b1);
        waitDone8(0, cyc);
        checkOutput("t3_done_cycles", cyc, 10);
        checkOutput("t3_pass", pass8, 7'd1);
        checkOutput("t3_fail", fail8, 7'd1);
        checkOutput("t3_ffid", ffid8, 8'h11);
        checkOutput("t3_max_addr", max_addr8, 6'd1);
        checkOutput("t3_opa_held", opa8, 8'h05);

        // 4: reset during WAIT of the third test
        $display("[TB] run 4: reset mid-run");
        loadGoodRom();
        applyStimulus(1'b0);
        repeat (12) @(posedge CLK);
        #1;
        checkOutput("t4_busy_pre", busy8, 1'b1);
        checkOutput("t4_pass_pre", pass8, 7'd2);
        checkOutput("t4_opa_pre", opa8, 8'h0C);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        checkOutput("t4_busy", busy8, 1'b0);
        checkOutput("t4_done", done8, 1'b0);
        checkOutput("t4_pass", pass8, 7'd0);
        checkOutput("t4_fail", fail8, 7'd0);
        checkOutput("t4_dut_ce", ce8, 1'b0);
        applyStimulus(1'b0);
        checkOutput("t4_restart_rd", stim_rd8, 1'b1);
        checkOutput("t4_restart_addr", stim_addr8, 6'd0);
        waitDone8(0, cyc);
        checkOutput("t4_pass_after", pass8, 7'd4);

        // 5: START while busy is ignored; START in FIN restarts
        $display("[TB] run 5: start while busy, restart from FIN");
        applyStimulus(1'b0);
        repeat (6) @(posedge CLK);
        #1;
        start8 = 1'b1;
        @(posedge CLK);
        #1;
        start8 = 1'b0;
        waitDone8(7, cyc);
        checkOutput("t5_done_cycles", cyc, 20);
        checkOutput("t5_pass", pass8, 7'd4);
        applyStimulus(1'b0);
        checkOutput("t5_restart_busy", busy8, 1'b1);
        checkOutput("t5_restart_done", done8, 1'b0);
        checkOutput("t5_restart_pass", pass8, 7'd0);
        checkOutput("t5_restart_addr", stim_addr8, 6'd0);
        waitDone8(0, cyc);
        checkOutput("t5_restart_cycles", cyc, 20);
        checkOutput("t5_restart_pass4", pass8, 7'd4);

        // RST and START on the same edge: reset wins
        @(posedge CLK);
        #1;
        RST    = 1'b1;
        start8 = 1'b1;
        @(posedge CLK);
        #1;
        RST    = 1'b0;
        start8 = 1'b0;
        checkOutput("rst_vs_start_busy", busy8, 1'b0);
        checkOutput("rst_vs_start_done", done8, 1'b0);

        // 6: 16-bit engine, full-width multiply compare
        $display("[TB] run 6: 16-bit multiply packet");
        for (int run = 0; run < 2; run++) begin
            if (run == 1) begin
                rom16 = mkPkt16(8'h61, 16'h0100, 16'h0100, 32'h0002_0000);
            end
            @(posedge CLK);
            #1;
            start16 = 1'b1;
            @(posedge CLK);
            #1;
            start16 = 1'b0;
            cyc = 0;
            while ((done16 !== 1'b1) && (cyc < 100)) begin
                @(posedge CLK);
                #1;
                cyc++;
            end
            checkOutput("t6_done_cycles", cyc, 5);
            if (run == 0) begin
                checkOutput("t6_pass", pass16, 2'd1);
                checkOutput("t6_fail", fail16, 2'd0);
            end else begin
                checkOutput("t6_hi_pass", pass16, 2'd0);
                checkOutput("t6_hi_fail", fail16, 2'd1);
                checkOutput("t6_hi_ffid", ffid16, 8'h61);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
